mc_controller: RTL and testbench
================================

Name: mc_controller

Overview:
- Multi-cycle control FSM for the MIPS-lite core (addu, subu, ori, lui, lw, sw, beq, jal, jr).
- Sequences the shared PC/IR/GRF/ALU/DM datapath across FETCH/DECODE/EXECUTE/MEM/WB cycles.
- Takes the instruction held in IR plus the ALU zero flag.
- Drives all write enables and mux selects each cycle.

Parameters:
- STATE_W, 4, width of state register and debug state port.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  synchronous, active-high reset.
- instr  input  32  current IR contents, stable from DECODE until the next FETCH.
- zero  input  1  ALU A==B flag, valid in BRANCH state.
- PCWrite  output  1  PC register load enable.
- PCSel  output  2  next-PC source: 00 PC+4, 01 branch target, 10 jump target, 11 GPR[rs].
- IRWrite  output  1  IR load enable.
- RegWrite  output  1  GRF write enable.
- RegDst  output  2  write-register select: 00 rt, 01 rd, 10 $31.
- WDSel  output  2  GRF write-data select: 00 ALUOut, 01 MDR, 10 PC (already PC+4).
- ALUSrc  output  1  ALU B select: 0 GPR[rt], 1 extended immediate.
- ALUOp  output  3  000 add, 001 sub, 010 or.
- EXTOp  output  2  00 zero-extend, 01 sign-extend, 10 imm<<16.
- MemWrite  output  1  DM write enable.
- state  output  STATE_W  current FSM state, for debug and verification.
- halted  output  1  illegal-instruction halt flag (see Optional Feature).

Behaviour:
- Decode rules:
  - addu = op 000000 / funct 100001; subu = op 0 / funct 100011; jr = op 0 / funct 001000.
  - ori 001101, lui 001111, lw 100011, sw 101011, beq 000100, jal 000011.
- State register updates on rising clk.
- reset=1 at an edge sets state to FETCH from any state, including mid-instruction; no partial write completes afterwards.
- While reset is high: PCWrite, IRWrite, RegWrite and MemWrite are forced to 0.
- Outputs are combinational from state and decoded instr. Selects not listed for a state are 00/0.
- FETCH: IRWrite=1, PCWrite=1, PCSel=00 -> DECODE.
- DECODE:
  - jal: RegWrite=1, RegDst=10, WDSel=10, PCWrite=1, PCSel=10 -> FETCH.
  - jr: PCWrite=1, PCSel=11 -> FETCH.
  - beq -> BRANCH; lw/sw -> MEMADR; addu/subu/ori/lui -> EXE.
  - other -> FETCH as a nop (Optional Feature changes this).
- EXE:
  - addu: ALUOp=000, ALUSrc=0. subu: ALUOp=001, ALUSrc=0.
  - ori: ALUOp=010, ALUSrc=1, EXTOp=00. lui: ALUOp=010, ALUSrc=1, EXTOp=10 (rs is $0 by encoding).
  - -> ALUWB.
- ALUWB: RegWrite=1, WDSel=00, RegDst=01 for addu/subu and 00 for ori/lui -> FETCH.
- MEMADR: ALUOp=000, ALUSrc=1, EXTOp=01. lw -> MEMRD; sw -> MEMWR.
- MEMWR: MemWrite=1 -> FETCH.
- MEMRD: no enables asserted (DM read into MDR) -> MEMWB.
- MEMWB: RegWrite=1, RegDst=00, WDSel=01 -> FETCH.
- BRANCH: ALUOp=001, ALUSrc=0, EXTOp=01. PCWrite=zero, PCSel=01 -> FETCH.
- Latency in cycles, FETCH to next FETCH: jal/jr/nop 2, beq 3, addu/subu/ori/lui/sw 4, lw 5.
- Write-enable exclusivity:
  - At most one of RegWrite and MemWrite is high in any cycle.
  - IRWrite is high only in FETCH.
- Writes to $0 are not suppressed here; the GRF suppresses them.
- Unused state encodings -> FETCH on the next edge.

Optional Feature:
- Macro ILLEGAL_HALT_EN.
- Defined:
  - An undecodable instr in DECODE -> HALT.
  - HALT holds all enables at 0 and sets halted=1 until reset.
- Undefined: no HALT state; unknown instructions are 2-cycle nops; halted is tied to 0.

Decomposition:
- Shared package mc_pkg holds:
  - opcode and funct constants;
  - PCSel, RegDst, WDSel, ALUOp and EXTOp encodings;
  - state encodings: FETCH=0, DECODE=1, EXE=2, ALUWB=3, MEMADR=4, MEMRD=5, MEMWR=6, MEMWB=7, BRANCH=8, HALT=9.
- One natural sub-module, mc_decode: combinational instr -> one-hot instruction class. It is reused by the FSM for transitions and output selects.

Test Plan:
- Reset: assert reset for 2 cycles in MEMWB with RegWrite pending -> state=0; PCWrite, IRWrite, RegWrite and MemWrite all 0; first post-reset cycle IRWrite=1.
- addu $3,$1,$2 (0x00221821): state sequence 0,1,2,3,0. Cycle 3 has RegWrite=1, RegDst=01, WDSel=00, ALUOp=000.
- lw $4,8($5) (0x8CA40008): state sequence 0,1,4,5,7,0, with EXTOp=01 in MEMADR. sw 0xACA40008 gives 0,1,4,6,0 with a single-cycle MemWrite.
- beq 0x10220003 with zero=1: PCWrite=1, PCSel=01 in BRANCH. With zero=0: PCWrite=0 and 3-cycle latency.
- jal 0x0C000C00: DECODE asserts RegWrite, RegDst=10, WDSel=10, PCWrite, PCSel=10 in one cycle. jr $31 (0x03E00008) gives PCSel=11.
- Illegal 0xFC000000:
  - With ILLEGAL_HALT_EN: state=9 and halted=1 held for 10 cycles, cleared by reset.
  - Without the macro: returns to FETCH after 2 cycles with no writes.

Source files
------------

// File: rtl/mc_pkg.sv
// Shared definitions for the MIPS-lite multi-cycle controller:
// opcode/funct constants, datapath select encodings, FSM state
// encodings and the one-hot instruction class used by decode and FSM.
package mc_pkg;

  // Opcode field values (instr[31:26])
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_LUI   = 6'b001111;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_JAL   = 6'b000011;

  // Funct field values for R-type (instr[5:0])
  localparam logic [5:0] FN_ADDU  = 6'b100001;
  localparam logic [5:0] FN_SUBU  = 6'b100011;
  localparam logic [5:0] FN_JR    = 6'b001000;

  // Next-PC source
  localparam logic [1:0] PCSEL_PC4 = 2'b00;
  localparam logic [1:0] PCSEL_BR  = 2'b01;
  localparam logic [1:0] PCSEL_J   = 2'b10;
  localparam logic [1:0] PCSEL_JR  = 2'b11;

  // Write-register select
  localparam logic [1:0] RD_RT = 2'b00;
  localparam logic [1:0] RD_RD = 2'b01;
  localparam logic [1:0] RD_RA = 2'b10;

  // GRF write-data select
  localparam logic [1:0] WD_ALU = 2'b00;
  localparam logic [1:0] WD_MDR = 2'b01;
  localparam logic [1:0] WD_PC  = 2'b10;

  // ALU operation
  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_OR  = 3'b010;

  // Immediate extension
  localparam logic [1:0] EXT_ZERO = 2'b00;
  localparam logic [1:0] EXT_SIGN = 2'b01;
  localparam logic [1:0] EXT_LUI  = 2'b10;

  // FSM state encodings (also exported on the debug state port)
  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_EXE    = 4'd2,
    S_ALUWB  = 4'd3,
    S_MEMADR = 4'd4,
    S_MEMRD  = 4'd5,
    S_MEMWR  = 4'd6,
    S_MEMWB  = 4'd7,
    S_BRANCH = 4'd8,
    S_HALT   = 4'd9
  } mc_state_e;

  // One-hot instruction class; exactly one field is set for any instr
  typedef struct packed {
    logic addu;
    logic subu;
    logic ori;
    logic lui;
    logic lw;
    logic sw;
    logic beq;
    logic jal;
    logic jr;
    logic illegal;
  } mc_class_t;

endpackage

// File: rtl/mc_decode.sv
// Combinational instruction classifier: maps the IR contents to a
// one-hot instruction class. Anything not recognised is flagged illegal.
module mc_decode
  import mc_pkg::*;
(
  input  logic [31:0] instr_i,
  output mc_class_t   cls_o
);

  logic [5:0] op_s;
  logic [5:0] funct_s;
  logic       unused_s;

  assign op_s     = instr_i[31:26];
  assign funct_s  = instr_i[5:0];
  // Register/immediate fields are irrelevant to classification
  assign unused_s = ^instr_i[25:6];

  // Classify by opcode, and by funct for R-type
  always_comb begin
    cls_o = '0;
    case (op_s)
      OP_RTYPE: begin
        case (funct_s)
          FN_ADDU: cls_o.addu    = 1'b1;
          FN_SUBU: cls_o.subu    = 1'b1;
          FN_JR:   cls_o.jr      = 1'b1;
          default: cls_o.illegal = 1'b1;
        endcase
      end
      OP_ORI:  cls_o.ori     = 1'b1;
      OP_LUI:  cls_o.lui     = 1'b1;
      OP_LW:   cls_o.lw      = 1'b1;
      OP_SW:   cls_o.sw      = 1'b1;
      OP_BEQ:  cls_o.beq     = 1'b1;
      OP_JAL:  cls_o.jal     = 1'b1;
      default: cls_o.illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/mc_controller.sv
// Multi-cycle control FSM for the MIPS-lite core. Sequences the shared
// PC/IR/GRF/ALU/DM datapath; all controls are decoded from the current
// state and the instruction class.
// Build option: define ILLEGAL_HALT_EN to trap undecodable instructions
// in a sticky HALT state (halted=1) instead of treating them as nops.
module mc_controller
  import mc_pkg::*;
#(
  parameter int STATE_W = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [31:0]        instr,
  input  logic               zero,
  output logic               PCWrite,
  output logic [1:0]         PCSel,
  output logic               IRWrite,
  output logic               RegWrite,
  output logic [1:0]         RegDst,
  output logic [1:0]         WDSel,
  output logic               ALUSrc,
  output logic [2:0]         ALUOp,
  output logic [1:0]         EXTOp,
  output logic               MemWrite,
  output logic [STATE_W-1:0] state,
  output logic               halted
);

  mc_state_e state_q;
  mc_state_e state_d;
  mc_class_t cls_s;

  logic pc_write_s;
  logic ir_write_s;
  logic reg_write_s;
  logic mem_write_s;
  logic halted_s;

  mc_decode u_decode (
    .instr_i (instr),
    .cls_o   (cls_s)
  );

  // State register; reset restarts at FETCH from anywhere
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_FETCH;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state and per-state control decode
  always_comb begin
    state_d     = S_FETCH;
    pc_write_s  = 1'b0;
    ir_write_s  = 1'b0;
    reg_write_s = 1'b0;
    mem_write_s = 1'b0;
    halted_s    = 1'b0;
    PCSel       = PCSEL_PC4;
    RegDst      = RD_RT;
    WDSel       = WD_ALU;
    ALUSrc      = 1'b0;
    ALUOp       = ALU_ADD;
    EXTOp       = EXT_ZERO;
    case (state_q)
      S_FETCH: begin
        ir_write_s = 1'b1;
        pc_write_s = 1'b1;
        state_d    = S_DECODE;
      end
      S_DECODE: begin
        if (cls_s.jal) begin
          // Link and jump complete in one cycle; PC already holds PC+4
          reg_write_s = 1'b1;
          RegDst      = RD_RA;
          WDSel       = WD_PC;
          pc_write_s  = 1'b1;
          PCSel       = PCSEL_J;
          state_d     = S_FETCH;
        end else if (cls_s.jr) begin
          pc_write_s = 1'b1;
          PCSel      = PCSEL_JR;
          state_d    = S_FETCH;
        end else if (cls_s.beq) begin
          state_d = S_BRANCH;
        end else if (cls_s.lw || cls_s.sw) begin
          state_d = S_MEMADR;
        end else if (cls_s.addu || cls_s.subu || cls_s.ori || cls_s.lui) begin
          state_d = S_EXE;
        end else begin
`ifdef ILLEGAL_HALT_EN
          state_d = S_HALT;
`else
          state_d = S_FETCH;
`endif
        end
      end
      S_EXE: begin
        if (cls_s.subu) begin
          ALUOp = ALU_SUB;
        end else if (cls_s.ori) begin
          ALUOp  = ALU_OR;
          ALUSrc = 1'b1;
          EXTOp  = EXT_ZERO;
        end else if (cls_s.lui) begin
          // rs is $0 for lui, so OR with the shifted immediate yields it
          ALUOp  = ALU_OR;
          ALUSrc = 1'b1;
          EXTOp  = EXT_LUI;
        end else begin
          ALUOp = ALU_ADD;
        end
        state_d = S_ALUWB;
      end
      S_ALUWB: begin
        reg_write_s = 1'b1;
        WDSel       = WD_ALU;
        RegDst      = (cls_s.addu || cls_s.subu) ? RD_RD : RD_RT;
        state_d     = S_FETCH;
      end
      S_MEMADR: begin
        ALUOp   = ALU_ADD;
        ALUSrc  = 1'b1;
        EXTOp   = EXT_SIGN;
        state_d = cls_s.sw ? S_MEMWR : S_MEMRD;
      end
      S_MEMWR: begin
        mem_write_s = 1'b1;
        state_d     = S_FETCH;
      end
      S_MEMRD: begin
        state_d = S_MEMWB;
      end
      S_MEMWB: begin
        reg_write_s = 1'b1;
        RegDst      = RD_RT;
        WDSel       = WD_MDR;
        state_d     = S_FETCH;
      end
      S_BRANCH: begin
        ALUOp      = ALU_SUB;
        ALUSrc     = 1'b0;
        EXTOp      = EXT_SIGN;
        pc_write_s = zero;
        PCSel      = PCSEL_BR;
        state_d    = S_FETCH;
      end
`ifdef ILLEGAL_HALT_EN
      S_HALT: begin
        halted_s = 1'b1;
        state_d  = S_HALT;
      end
`endif
      default: begin
        state_d = S_FETCH;
      end
    endcase
  end

  // Write enables are suppressed for as long as reset is held
  always_comb begin
    if (reset) begin
      PCWrite  = 1'b0;
      IRWrite  = 1'b0;
      RegWrite = 1'b0;
      MemWrite = 1'b0;
    end else begin
      PCWrite  = pc_write_s;
      IRWrite  = ir_write_s;
      RegWrite = reg_write_s;
      MemWrite = mem_write_s;
    end
  end

  assign state  = STATE_W'(state_q);
  assign halted = halted_s;

endmodule

// File: tb/tb_mc_controller.sv
// Directed self-checking bench for mc_controller. Outputs are sampled
// shortly after the falling edge; the FSM advances on the rising edge.
module tb_mc_controller;

  logic        clk;
  logic        reset;
  logic [31:0] instr;
  logic        zero;
  logic        PCWrite;
  logic [1:0]  PCSel;
  logic        IRWrite;
  logic        RegWrite;
  logic [1:0]  RegDst;
  logic [1:0]  WDSel;
  logic        ALUSrc;
  logic [2:0]  ALUOp;
  logic [1:0]  EXTOp;
  logic        MemWrite;
  logic [3:0]  state;
  logic        halted;

  int checks = 0;
  int errors = 0;

  mc_controller #(.STATE_W(4)) dut (
    .clk      (clk),
    .reset    (reset),
    .instr    (instr),
    .zero     (zero),
    .PCWrite  (PCWrite),
    .PCSel    (PCSel),
    .IRWrite  (IRWrite),
    .RegWrite (RegWrite),
    .RegDst   (RegDst),
    .WDSel    (WDSel),
    .ALUSrc   (ALUSrc),
    .ALUOp    (ALUOp),
    .EXTOp    (EXTOp),
    .MemWrite (MemWrite),
    .state    (state),
    .halted   (halted)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Write-enable exclusivity monitored every cycle
  always @(negedge clk) begin
    #2;
    checks++;
    if ((RegWrite && MemWrite) || (IRWrite && state !== 4'd0)) begin
      errors++;
      $display("FAIL excl state=%0d RegWrite=%b MemWrite=%b IRWrite=%b, required no overlap and IRWrite only in state 0",
               state, RegWrite, MemWrite, IRWrite);
    end
  end

  task automatic test_reset();
    reset = 1'b1; instr = 32'h0; zero = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    checks++;
    if (state !== 4'd0 || {PCWrite, IRWrite, RegWrite, MemWrite} !== 4'b0000) begin
      errors++;
      $display("FAIL reset_hold state=%0d en=%b, required 0 and 0000", state,
               {PCWrite, IRWrite, RegWrite, MemWrite});
    end
    reset = 1'b0;
    #1;
    checks++;
    if (IRWrite !== 1'b1) begin
      errors++; $display("FAIL reset_release IRWrite=%b, required 1", IRWrite);
    end
    // Drive lw up to MEMWB, then reset with the GRF write pending
    instr = 32'h8CA40008;
    repeat (4) @(negedge clk);
    #1;
    checks++;
    if (state !== 4'd7 || RegWrite !== 1'b1) begin
      errors++; $display("FAIL reset_pre state=%0d RegWrite=%b, required 7 and 1", state, RegWrite);
    end
    reset = 1'b1;
    #1;
    checks++;
    if (RegWrite !== 1'b0) begin
      errors++; $display("FAIL reset_force RegWrite=%b, required 0", RegWrite);
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    #1;
    checks++;
    if (state !== 4'd0 || {PCWrite, IRWrite, RegWrite, MemWrite} !== 4'b0000) begin
      errors++;
      $display("FAIL reset_mid state=%0d en=%b, required 0 and 0000", state,
               {PCWrite, IRWrite, RegWrite, MemWrite});
    end
    reset = 1'b0;
    #1;
    checks++;
    if (IRWrite !== 1'b1 || PCWrite !== 1'b1 || PCSel !== 2'b00) begin
      errors++;
      $display("FAIL reset_first IRWrite=%b PCWrite=%b PCSel=%b, required 1 1 00", IRWrite, PCWrite, PCSel);
    end
  endtask

  // R-type and immediate ALU ops: 0,1,2,3,0
  task automatic test_alu(input logic [31:0] ins, input logic [2:0] exp_op,
                          input logic exp_src, input logic [1:0] exp_ext,
                          input logic [1:0] exp_dst, input string nm);
    logic [3:0] seq [5];
    seq = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd0};
    instr = ins;
    for (int i = 0; i < 5; i++) begin
      #1;
      checks++;
      if (state !== seq[i]) begin
        errors++; $display("FAIL %s_state[%0d] got %0d, required %0d", nm, i, state, seq[i]);
      end
      if (i == 2) begin
        checks++;
        if ({ALUOp, ALUSrc, EXTOp, RegWrite, MemWrite} !== {exp_op, exp_src, exp_ext, 1'b0, 1'b0}) begin
          errors++;
          $display("FAIL %s_exe op=%b src=%b ext=%b rw=%b mw=%b, required %b %b %b 0 0",
                   nm, ALUOp, ALUSrc, EXTOp, RegWrite, MemWrite, exp_op, exp_src, exp_ext);
        end
      end
      if (i == 3) begin
        checks++;
        if ({RegWrite, RegDst, WDSel, PCWrite} !== {1'b1, exp_dst, 2'b00, 1'b0}) begin
          errors++;
          $display("FAIL %s_wb rw=%b dst=%b wd=%b pcw=%b, required 1 %b 00 0",
                   nm, RegWrite, RegDst, WDSel, PCWrite, exp_dst);
        end
      end
      if (i < 4) @(negedge clk);
    end
  endtask

  task automatic test_lw();
    logic [3:0] seq [6];
    seq = '{4'd0, 4'd1, 4'd4, 4'd5, 4'd7, 4'd0};
    instr = 32'h8CA40008;
    for (int i = 0; i < 6; i++) begin
      #1;
      checks++;
      if (state !== seq[i]) begin
        errors++; $display("FAIL lw_state[%0d] got %0d, required %0d", i, state, seq[i]);
      end
      if (i == 2) begin
        checks++;
        if ({EXTOp, ALUSrc, ALUOp} !== {2'b01, 1'b1, 3'b000}) begin
          errors++; $display("FAIL lw_memadr ext=%b src=%b op=%b, required 01 1 000", EXTOp, ALUSrc, ALUOp);
        end
      end
      if (i == 3) begin
        checks++;
        if ({PCWrite, RegWrite, MemWrite} !== 3'b000) begin
          errors++; $display("FAIL lw_memrd en=%b, required 000", {PCWrite, RegWrite, MemWrite});
        end
      end
      if (i == 4) begin
        checks++;
        if ({RegWrite, RegDst, WDSel} !== {1'b1, 2'b00, 2'b01}) begin
          errors++; $display("FAIL lw_memwb rw=%b dst=%b wd=%b, required 1 00 01", RegWrite, RegDst, WDSel);
        end
      end
      if (i < 5) @(negedge clk);
    end
  endtask

  task automatic test_sw();
    logic [3:0] seq [5];
    int mw_cnt;
    seq = '{4'd0, 4'd1, 4'd4, 4'd6, 4'd0};
    mw_cnt = 0;
    instr = 32'hACA40008;
    for (int i = 0; i < 5; i++) begin
      #1;
      checks++;
      if (state !== seq[i]) begin
        errors++; $display("FAIL sw_state[%0d] got %0d, required %0d", i, state, seq[i]);
      end
      if (MemWrite === 1'b1) mw_cnt++;
      if (i < 4) @(negedge clk);
    end
    checks++;
    if (mw_cnt != 1) begin
      errors++; $display("FAIL sw_memwrite_cycles got %0d, required 1", mw_cnt);
    end
  endtask

  task automatic test_beq(input logic z);
    logic [3:0] seq [4];
    seq = '{4'd0, 4'd1, 4'd8, 4'd0};
    instr = 32'h10220003;
    zero = z;
    for (int i = 0; i < 4; i++) begin
      #1;
      checks++;
      if (state !== seq[i]) begin
        errors++; $display("FAIL beq%0d_state[%0d] got %0d, required %0d", z, i, state, seq[i]);
      end
      if (i == 2) begin
        checks++;
        if ({PCWrite, PCSel, ALUOp, ALUSrc, EXTOp} !== {z, 2'b01, 3'b001, 1'b0, 2'b01}) begin
          errors++;
          $display("FAIL beq%0d_branch pcw=%b sel=%b op=%b src=%b ext=%b, required %b 01 001 0 01",
                   z, PCWrite, PCSel, ALUOp, ALUSrc, EXTOp, z);
        end
      end
      if (i < 3) @(negedge clk);
    end
    zero = 1'b0;
  endtask

  task automatic test_jumps();
    instr = 32'h0C000C00;
    @(negedge clk); #1;
    checks++;
    if (state !== 4'd1 || {RegWrite, RegDst, WDSel, PCWrite, PCSel} !== {1'b1, 2'b10, 2'b10, 1'b1, 2'b10}) begin
      errors++;
      $display("FAIL jal_decode state=%0d rw=%b dst=%b wd=%b pcw=%b sel=%b, required 1 1 10 10 1 10",
               state, RegWrite, RegDst, WDSel, PCWrite, PCSel);
    end
    @(negedge clk); #1;
    checks++;
    if (state !== 4'd0) begin
      errors++; $display("FAIL jal_return state=%0d, required 0", state);
    end
    instr = 32'h03E00008;
    @(negedge clk); #1;
    checks++;
    if (state !== 4'd1 || {PCWrite, PCSel, RegWrite, MemWrite} !== {1'b1, 2'b11, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL jr_decode state=%0d pcw=%b sel=%b rw=%b mw=%b, required 1 1 11 0 0",
               state, PCWrite, PCSel, RegWrite, MemWrite);
    end
    @(negedge clk); #1;
    checks++;
    if (state !== 4'd0) begin
      errors++; $display("FAIL jr_return state=%0d, required 0", state);
    end
  endtask

  task automatic test_illegal();
    instr = 32'hFC000000;
    @(negedge clk); #1;
    checks++;
    if (state !== 4'd1 || {PCWrite, RegWrite, MemWrite, halted} !== 4'b0000) begin
      errors++;
      $display("FAIL ill_decode state=%0d en=%b, required 1 0000", state, {PCWrite, RegWrite, MemWrite, halted});
    end
`ifdef ILLEGAL_HALT_EN
    for (int i = 0; i < 10; i++) begin
      @(negedge clk); #1;
      checks++;
      if (state !== 4'd9 || halted !== 1'b1 || {PCWrite, IRWrite, RegWrite, MemWrite} !== 4'b0000) begin
        errors++;
        $display("FAIL ill_halt[%0d] state=%0d halted=%b en=%b, required 9 1 0000", i, state, halted,
                 {PCWrite, IRWrite, RegWrite, MemWrite});
      end
    end
    reset = 1'b1;
    @(negedge clk); #1;
    checks++;
    if (state !== 4'd0 || halted !== 1'b0) begin
      errors++; $display("FAIL ill_clear state=%0d halted=%b, required 0 0", state, halted);
    end
    reset = 1'b0;
`else
    @(negedge clk); #1;
    checks++;
    if (state !== 4'd0 || halted !== 1'b0) begin
      errors++; $display("FAIL ill_nop state=%0d halted=%b, required 0 0", state, halted);
    end
`endif
  endtask

  // Run-time bound
  initial begin
    #100000;
    $display("FAIL timeout simulation exceeded bound");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_alu(32'h00221821, 3'b000, 1'b0, 2'b00, 2'b01, "addu");
    test_alu(32'h00221823, 3'b001, 1'b0, 2'b00, 2'b01, "subu");
    test_alu(32'h34220005, 3'b010, 1'b1, 2'b00, 2'b00, "ori");
    test_alu(32'h3C010005, 3'b010, 1'b1, 2'b10, 2'b00, "lui");
    test_lw();
    test_sw();
    test_beq(1'b1);
    test_beq(1'b0);
    test_jumps();
    test_illegal();
    // back-to-back: addu immediately after the previous instruction
    test_alu(32'h00221821, 3'b000, 1'b0, 2'b00, 2'b01, "addu_b2b");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
